led_alert_sequencer: RTL and testbench

- Shares the board's 4-LED blink indicator between four independent requesters (alarm, status, error and user sources).
- A round-robin arbiter picks one requester at a time.
- The sequencer then plays that requester's programmed number of on/off blinks, followed by a dark gap, and pulses a per-requester done.
- It owns its own tick prescaler, which replaces free-running blink counters in the display path.

---
 rtl/led_alert_sequencer.sv | 175 +++++++++++++++++
 tb/tb_led_alert_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_alert_sequencer.sv
`timescale 1ns/1ps
// led_alert_sequencer
// Shares the board's 4-LED blink indicator between four requesters. A
// round-robin arbiter picks an owner, which then gets its programmed number
// of on/off blinks, a dark gap, and a one-cycle done pulse. The module owns
// the blink-phase prescaler so the display path needs no free-running counter.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; round-robin search for the next request
//   ON    | LEDs lit for one phase
//   OFF   | LEDs dark for one phase; last OFF of the sequence leads to GAP
//   GAP   | dark phases after the final blink, then done and back to IDLE
module led_alert_sequencer #(
    parameter int TICK_DIV  = 25_000_000,
    parameter int CNT_W     = 27,
    parameter int GAP_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  req,
    input  logic [11:0] blink_cnt,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        busy,
    output logic [3:0]  leds
);

    localparam int               GAP_W      = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
    localparam logic [CNT_W-1:0] PRESC_LOAD = CNT_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_TICKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] presc, presc_nxt;
    logic [3:0]       remaining, remaining_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [1:0]       last, last_nxt;
    logic [3:0]       grant_nxt;
    logic [3:0]       done_nxt;
    logic [3:0]       leds_nxt;
    logic             busy_nxt;
    logic             tick;
    logic             abandon;
    logic             found;
    logic [1:0]       win;
    logic [2:0]       win_field;

    // Phase boundary: prescaler terminal count, only counted while enabled.
    assign tick = (presc == '0) && en;

    // The owner dropping its request ends the sequence immediately, ahead of any tick.
    assign abandon = (state != IDLE) && ((req & grant) == 4'b0000);

    // Round-robin search starting one past the previous winner.
    always_comb begin
        found = 1'b0;
        win   = last;
        for (int s = 1; s <= 4; s++) begin
            if (!found && req[last + 2'(s)]) begin
                found = 1'b1;
                win   = last + 2'(s);
            end
        end
    end

    // Blink-count field belonging to the search winner.
    always_comb begin
        case (win)
            2'd0:    win_field = blink_cnt[2:0];
            2'd1:    win_field = blink_cnt[5:3];
            2'd2:    win_field = blink_cnt[8:6];
            default: win_field = blink_cnt[11:9];
        endcase
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        state_nxt     = state;
        presc_nxt     = presc;
        remaining_nxt = remaining;
        gap_nxt       = gap_cnt;
        last_nxt      = last;
        grant_nxt     = grant;
        done_nxt      = 4'b0000;

        if (state != IDLE && en) begin
            presc_nxt = (presc == '0) ? PRESC_LOAD : presc - CNT_W'(1);
        end

        unique case (state)
            IDLE: begin
                if (en && found) begin
                    state_nxt     = ON;
                    grant_nxt     = 4'b0001 << win;
                    last_nxt      = win;
                    presc_nxt     = PRESC_LOAD;
                    remaining_nxt = (win_field == 3'd0) ? 4'd8 : {1'b0, win_field};
                end
            end
            ON: begin
                if (tick) begin
                    state_nxt = OFF;
                end
            end
            OFF: begin
                if (tick) begin
                    if (remaining == 4'd1) begin
                        state_nxt = GAP;
                        gap_nxt   = GAP_LOAD;
                    end else begin
                        remaining_nxt = remaining - 4'd1;
                        state_nxt     = ON;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    // A zero gap setting still yields one dark phase.
                    if (gap_cnt <= GAP_W'(1)) begin
                        state_nxt = IDLE;
                        gap_nxt   = '0;
                        grant_nxt = 4'b0000;
                        done_nxt  = grant;
                    end else begin
                        gap_nxt = gap_cnt - GAP_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (abandon) begin
            state_nxt = IDLE;
            grant_nxt = 4'b0000;
            done_nxt  = 4'b0000;
        end

        busy_nxt = (grant_nxt != 4'b0000);
        leds_nxt = ((state_nxt == ON) && en) ? 4'b1111 : 4'b0000;
    end

    // State and output registers; synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= PRESC_LOAD;
            remaining <= 4'd0;
            gap_cnt   <= '0;
            last      <= 2'd3;
            grant     <= 4'b0000;
            done      <= 4'b0000;
            busy      <= 1'b0;
            leds      <= 4'b0000;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            remaining <= remaining_nxt;
            gap_cnt   <= gap_nxt;
            last      <= last_nxt;
            grant     <= grant_nxt;
            done      <= done_nxt;
            busy      <= busy_nxt;
            leds      <= leds_nxt;
        end
    end

endmodule

// File: tb/tb_led_alert_sequencer.sv
`timescale 1ns/1ps
// Testbench for led_alert_sequencer with TICK_DIV=4, GAP_TICKS=2.
// The driver pushes the expected grant order (owner, blink count) into a
// queue when it raises requests; a monitor pops an entry whenever a grant is
// due and tracks elapsed enabled cycles of the current owner to predict
// grant, busy, leds and done every cycle.
module tb_led_alert_sequencer;

    localparam int TD = 4;
    localparam int GT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [11:0] blink_cnt = 12'h000;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  leds;

    led_alert_sequencer #(
        .TICK_DIV  (TD),
        .CNT_W     (27),
        .GAP_TICKS (GT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .blink_cnt (blink_cnt),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        int owner;
        int n;
    } exp_t;

    exp_t exp_q[$];
    int   g_times[$];
    int   g_own[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   tb_last = 3;

    bit         m_active = 1'b0;
    int         m_owner = 0;
    int         m_n = 0;
    int         m_e = 0;
    logic [3:0] e_grant;
    logic [3:0] e_done;
    logic [3:0] e_leds;
    exp_t       m_it;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
        end
    endtask

    // Expected grant order for a set of simultaneously raised requests.
    task automatic push_order(input logic [3:0] mask);
        logic [3:0] pend;
        int l, f, idx;
        exp_t it;
        pend = mask;
        l = tb_last;
        for (int k = 0; k < 4; k++) begin
            for (int s = 1; s <= 4; s++) begin
                idx = (l + s) % 4;
                if (pend[idx]) begin
                    f = int'((blink_cnt >> (3 * idx)) & 12'h007);
                    it.owner = idx;
                    it.n = (f == 0) ? 8 : f;
                    exp_q.push_back(it);
                    pend[idx] = 1'b0;
                    l = idx;
                    break;
                end
            end
        end
        tb_last = l;
    endtask

    // Monitor: advance the reference with the inputs captured at this edge, then compare.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            e_done = 4'b0000;
            if (reset) begin
                m_active = 1'b0;
            end else if (m_active) begin
                if (!req[m_owner]) begin
                    m_active = 1'b0;
                end else if (en) begin
                    m_e++;
                    if (m_e == (2 * m_n + GT) * TD) begin
                        m_active = 1'b0;
                        e_done = 4'b0001 << m_owner;
                    end
                end
            end else if (en && req != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL grant_queue cycle %0d: got grant with empty queue, expected entry", cyc);
                end else begin
                    m_it = exp_q.pop_front();
                    m_active = 1'b1;
                    m_owner = m_it.owner;
                    m_n = m_it.n;
                    m_e = 0;
                end
            end
            e_grant = m_active ? (4'b0001 << m_owner) : 4'b0000;
            e_leds = (m_active && en && ((m_e / TD) % 2 == 0) && (m_e < 2 * m_n * TD)) ? 4'hF : 4'h0;
            chk("grant", int'(grant), int'(e_grant));
            chk("done", int'(done), int'(e_done));
            chk("busy", int'(busy), int'(m_active));
            chk("leds", int'(leds), int'(e_leds));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = 4'b0000;
        en = 1'b1;
        exp_q.delete();
        tb_last = 3;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Raise a request set, drop each on its done; optional enable gap, abandon, reset.
    task automatic run_batch(input logic [3:0] mask, input logic [11:0] fields,
                             input int en_at, input int en_len,
                             input int ab_owner, input int ab_delay,
                             input int rst_at, output int done_t, output int fg);
        int t, own_start;
        logic [3:0] prev_g;
        t = 0;
        own_start = 0;
        prev_g = 4'b0000;
        fg = -1;
        done_t = -1;
        g_times.delete();
        g_own.delete();
        @(negedge clk);
        blink_cnt = fields;
        req = mask;
        push_order(mask);
        while (req != 4'b0000 && t < 3000) begin
            @(negedge clk);
            t++;
            if (reset) reset = 1'b0;
            if (grant != 4'b0000 && prev_g == 4'b0000) begin
                own_start = t;
                if (fg < 0) fg = t;
                g_times.push_back(t);
                g_own.push_back(int'(grant));
            end
            prev_g = grant;
            for (int i = 0; i < 4; i++) begin
                if (grant[i]) blink_cnt[3*i +: 3] = 3'($urandom_range(0, 7));
            end
            if (fg >= 0 && en_at >= 0 && t == fg + en_at) en = 1'b0;
            if (fg >= 0 && en_at >= 0 && t == fg + en_at + en_len) en = 1'b1;
            if (ab_owner >= 0 && grant[ab_owner] && (t - own_start) == ab_delay) req[ab_owner] = 1'b0;
            if (done != 4'b0000) done_t = t;
            for (int i = 0; i < 4; i++) begin
                if (done[i]) req[i] = 1'b0;
            end
            if (fg >= 0 && rst_at >= 0 && t == fg + rst_at) begin
                reset = 1'b1;
                exp_q.delete();
                tb_last = 3;
                push_order(req);
            end
        end
        n_checks++;
        if (t >= 3000) begin
            n_fail++;
            $display("FAIL batch_timeout cycle %0d: req still %b after %0d cycles, expected drained", cyc, req, t);
        end
        req = 4'b0000;
        en = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        int dt, fg;
        logic [3:0] m;
        int ab_o, ab_d, e_at, e_len;

        repeat (3) @(negedge clk);
        en = 1'b1;
        reset = 1'b0;

        // Single sequence, 3 blinks on requester 2.
        run_batch(4'b0100, 12'h0C0, -1, 0, -1, 0, -1, dt, fg);
        chk("s1_grant_cycle", fg, 1);
        chk("s1_done_cycle", dt, 33);

        // Round robin across all four, one blink each.
        do_reset();
        run_batch(4'b1111, 12'h249, -1, 0, -1, 0, -1, dt, fg);
        chk("s2_grant_count", g_times.size(), 4);
        for (int k = 0; k < g_times.size(); k++) begin
            chk("s2_grant_owner", g_own[k], 1 << k);
            if (k > 0) chk("s2_grant_spacing", g_times[k] - g_times[k-1], 17);
        end

        // Abandon requester 1 in its second ON phase; requester 2 follows.
        run_batch(4'b0110, 12'h050, -1, 0, 1, 9, -1, dt, fg);
        chk("s3_grant_count", g_times.size(), 2);
        if (g_times.size() >= 2) begin
            chk("s3_first_owner", g_own[0], 4'b0010);
            chk("s3_regrant_gap", g_times[1] - g_times[0], 11);
        end

        // Enable low for 10 cycles in the first OFF phase.
        run_batch(4'b0100, 12'h0C0, 6, 10, -1, 0, -1, dt, fg);
        chk("s4_done_cycle", dt, 43);

        // Zero count means eight blinks.
        run_batch(4'b0001, 12'h000, -1, 0, -1, 0, -1, dt, fg);
        chk("s5_done_latency", dt - fg, 72);

        // Reset during the first ON phase with all requests held.
        do_reset();
        run_batch(4'b1111, 12'h249, -1, 0, -1, 0, 2, dt, fg);
        if (g_times.size() >= 2) begin
            chk("s6_owner_after_reset", g_own[1], 4'b0001);
            chk("s6_regrant_gap", g_times[1] - g_times[0], 4);
        end else begin
            chk("s6_grant_count", g_times.size(), 5);
        end

        // Randomized batches.
        for (int r = 0; r < 14; r++) begin
            m = 4'($urandom_range(1, 15));
            ab_o = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
            ab_d = int'($urandom_range(0, 40));
            e_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
            e_len = int'($urandom_range(1, 12));
            run_batch(m, 12'($urandom), e_at, e_len, ab_o, ab_d, -1, dt, fg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
